// File: rtl/cpu_controller.sv
`default_nettype none
// cpu_controller: Moore sequencer driving the cpu datapath strobes, one instruction per s handshake.
// Outputs are registered and decoded from the next state, so they always match the state register.
module cpu_controller #(
  parameter bit IMM_FLAGS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] aluop,
  output logic       loadc,
  output logic       loads,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_IMM_ALU   = 3'd3,
    S_GET_A     = 3'd4,
    S_GET_B     = 3'd5,
    S_ALU       = 3'd6,
    S_WRITE_REG = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;

  state_t     state_q, state_d;
  logic [2:0] opc_q, opc_d;
  logic [1:0] op_q, op_d;

  logic       w_q, w_d;
  logic [2:0] nsel_q, nsel_d;
  logic       vsel_q, vsel_d;
  logic       write_q, write_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       asel_q, asel_d;
  logic       bsel_q, bsel_d;
  logic [1:0] aluop_q, aluop_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       illegal_q, illegal_d;

  function automatic logic is_legal(input logic [2:0] oc, input logic [1:0] o);
    return ((oc == OPC_MOV) && ((o == 2'b10) || (o == 2'b00))) || (oc == OPC_ALU);
  endfunction

  // Next state; opcode/op are captured only on acceptance so the IR may reload mid-instruction.
  always_comb begin
    state_d = S_WAIT;
    opc_d   = opc_q;
    op_d    = op_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          opc_d   = opcode;
          op_d    = op;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DECODE: begin
        case ({opc_q, op_q})
          {OPC_MOV, 2'b10}:                                        state_d = S_WRITE_IMM;
          {OPC_MOV, 2'b00}, {OPC_ALU, OP_MVN}:                     state_d = S_GET_B;
          {OPC_ALU, 2'b00}, {OPC_ALU, OP_CMP}, {OPC_ALU, 2'b10}:   state_d = S_GET_A;
          default:                                                 state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = IMM_FLAGS ? S_IMM_ALU : S_WAIT;
      S_IMM_ALU:   state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = ((opc_q == OPC_ALU) && (op_q == OP_CMP)) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w_d       = 1'b0;
    nsel_d    = 3'b000;
    vsel_d    = 1'b0;
    write_d   = 1'b0;
    loada_d   = 1'b0;
    loadb_d   = 1'b0;
    asel_d    = 1'b0;
    bsel_d    = 1'b0;
    aluop_d   = 2'b00;
    loadc_d   = 1'b0;
    loads_d   = 1'b0;
    illegal_d = 1'b0;
    case (state_d)
      S_WAIT:      w_d = 1'b1;
      S_DECODE:    illegal_d = !is_legal(opc_d, op_d);
      S_WRITE_IMM: begin
        nsel_d  = 3'b001;
        vsel_d  = 1'b1;
        write_d = 1'b1;
      end
      S_IMM_ALU: begin
        asel_d  = 1'b1;
        bsel_d  = 1'b1;
        loadc_d = 1'b1;
        loads_d = 1'b1;
      end
      S_GET_A: begin
        nsel_d  = 3'b001;
        loada_d = 1'b1;
      end
      S_GET_B: begin
        nsel_d  = 3'b100;
        loadb_d = 1'b1;
      end
      S_ALU: begin
        loadc_d = 1'b1;
        loads_d = 1'b1;
        asel_d  = (opc_d == OPC_MOV) || (op_d == OP_MVN);
        aluop_d = (opc_d == OPC_ALU) ? op_d : 2'b00;
      end
      S_WRITE_REG: begin
        nsel_d  = 3'b010;
        write_d = 1'b1;
      end
      default: w_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_WAIT;
      opc_q     <= 3'b000;
      op_q      <= 2'b00;
      w_q       <= 1'b1;
      nsel_q    <= 3'b000;
      vsel_q    <= 1'b0;
      write_q   <= 1'b0;
      loada_q   <= 1'b0;
      loadb_q   <= 1'b0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
      aluop_q   <= 2'b00;
      loadc_q   <= 1'b0;
      loads_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      op_q      <= op_d;
      w_q       <= w_d;
      nsel_q    <= nsel_d;
      vsel_q    <= vsel_d;
      write_q   <= write_d;
      loada_q   <= loada_d;
      loadb_q   <= loadb_d;
      asel_q    <= asel_d;
      bsel_q    <= bsel_d;
      aluop_q   <= aluop_d;
      loadc_q   <= loadc_d;
      loads_q   <= loads_d;
      illegal_q <= illegal_d;
    end
  end

  assign w       = w_q;
  assign nsel    = nsel_q;
  assign vsel    = vsel_q;
  assign write   = write_q;
  assign loada   = loada_q;
  assign loadb   = loadb_q;
  assign asel    = asel_q;
  assign bsel    = bsel_q;
  assign aluop   = aluop_q;
  assign loadc   = loadc_q;
  assign loads   = loads_q;
  assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// tb_cpu_controller: directed bench for cpu_controller with a small bench-side datapath model.
module tb_cpu_controller;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        s     = 1'b0;
  logic [15:0] ir    = 16'h0000;

  logic       w, vsel, write, loada, loadb, asel, bsel, loadc, loads, illegal;
  logic [2:0] nsel;
  logic [1:0] aluop;

  int checks   = 0;
  int failures = 0;

  cpu_controller #(.IMM_FLAGS(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .opcode  (ir[15:13]),
    .op      (ir[12:11]),
    .w       (w),
    .nsel    (nsel),
    .vsel    (vsel),
    .write   (write),
    .loada   (loada),
    .loadb   (loadb),
    .asel    (asel),
    .bsel    (bsel),
    .aluop   (aluop),
    .loadc   (loadc),
    .loads   (loads),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {w, nsel, vsel, write, loada, loadb, asel, bsel, aluop, loadc, loads, illegal};

  // Datapath model: regfile, A/B/C, shifter, ALU, status {N,V,Z}, driven by the DUT strobes.
  logic [15:0] R [8] = '{default: 16'h0000};
  logic [15:0] A = 16'h0, B = 16'h0, C = 16'h0;
  logic [2:0]  stat = 3'b000;
  logic [15:0] sx, sh, ain, bin, res;
  logic [2:0]  rsel;
  logic        v;

  always_comb begin
    sx = {{8{ir[7]}}, ir[7:0]};
    case (nsel)
      3'b001:  rsel = ir[10:8];
      3'b010:  rsel = ir[7:5];
      3'b100:  rsel = ir[2:0];
      default: rsel = 3'd0;
    endcase
    case (ir[4:3])
      2'b00:   sh = B;
      2'b01:   sh = B << 1;
      2'b10:   sh = B >> 1;
      default: sh = {B[15], B[15:1]};
    endcase
    ain = asel ? 16'h0000 : A;
    bin = bsel ? sx : sh;
    v   = 1'b0;
    case (aluop)
      2'b00: begin
        res = ain + bin;
        v   = (ain[15] == bin[15]) && (res[15] != ain[15]);
      end
      2'b01: begin
        res = ain - bin;
        v   = (ain[15] != bin[15]) && (res[15] != ain[15]);
      end
      2'b10:   res = ain & bin;
      default: res = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) R[rsel] <= vsel ? sx : C;
    if (loada) A <= R[rsel];
    if (loadb) B <= R[rsel];
    if (loadc) C <= res;
    if (loads) stat <= {res[15], v, (res == 16'h0000)};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] eo(input logic ew, input logic [2:0] ens, input logic evs,
                                     input logic ewr, input logic ela, input logic elb,
                                     input logic eas, input logic ebs, input logic [1:0] eop,
                                     input logic elc, input logic els, input logic eil);
    return {ew, ens, evs, ewr, ela, elb, eas, ebs, eop, elc, els, eil};
  endfunction

  task automatic start(input logic [15:0] instr);
    ir = instr;
    s  = 1'b1;
    @(negedge clk);
    s  = 1'b0;
  endtask

  task automatic step(input string tag, input logic [14:0] e);
    check_eq(tag, {17'h0, outs}, {17'h0, e});
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [15:0] instr, input bit corrupt,
                     output int lat, output int nw, output int ni);
    start(instr);
    lat = 0; nw = 0; ni = 0;
    while (!w && lat < 12) begin
      nw += int'(write);
      ni += int'(illegal);
      if (corrupt && lat == 1) ir[15:13] = 3'b111;
      @(negedge clk);
      lat++;
    end
    if (!w) check_eq({tag, "_timeout"}, {31'h0, w}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int lat, nw, ni;
    logic [14:0] o_wait, o_zero, o_geta, o_getb, o_wreg, o_wimm, o_ialu, o_ill;
    o_wait = eo(1, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    o_zero = 15'h0000;
    o_geta = eo(0, 3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    o_getb = eo(0, 3'b100, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    o_wreg = eo(0, 3'b010, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    o_wimm = eo(0, 3'b001, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    o_ialu = eo(0, 3'b000, 0, 0, 0, 0, 1, 1, 2'b00, 1, 1, 0);
    o_ill  = eo(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Reset held with s=1: nothing may launch.
    reset = 1'b0; s = 1'b1; ir = 16'hD105;
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {17'h0, outs}, {17'h0, o_wait});
    @(negedge clk);
    check_eq("rst_hold", {17'h0, outs}, {17'h0, o_wait});
    s = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("rst_release", {17'h0, outs}, {17'h0, o_wait});

    // MOV R1,#5
    start(16'hD105);
    step("movi_decode", o_zero);
    step("movi_wimm", o_wimm);
    step("movi_ialu", o_ialu);
    check_eq("movi_wait", {17'h0, outs}, {17'h0, o_wait});
    check_eq("movi_r1", {16'h0, R[1]}, 32'd5);
    check_eq("movi_c", {16'h0, C}, 32'd5);
    check_eq("movi_stat", {29'h0, stat}, 32'b000);

    run("movi_r2", 16'hD203, 1'b0, lat, nw, ni);
    check_eq("movi_lat", lat, 3);
    check_eq("movi_r2", {16'h0, R[2]}, 32'd3);

    // ADD R3,R1,R2
    start(16'hA162);
    step("add_decode", o_zero);
    step("add_geta", o_geta);
    step("add_getb", o_getb);
    step("add_alu", eo(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0));
    step("add_wreg", o_wreg);
    check_eq("add_wait", {17'h0, outs}, {17'h0, o_wait});
    check_eq("add_r3", {16'h0, R[3]}, 32'd8);

    // CMP R4,R1 with R4=16
    run("movi_r4", 16'hD410, 1'b0, lat, nw, ni);
    start(16'hAC01);
    step("cmp_decode", o_zero);
    step("cmp_geta", o_geta);
    step("cmp_getb", o_getb);
    step("cmp_alu", eo(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0));
    check_eq("cmp_wait", {17'h0, outs}, {17'h0, o_wait});
    check_eq("cmp_c", {16'h0, C}, 32'd11);
    check_eq("cmp_stat", {29'h0, stat}, 32'b000);

    run("cmp66", 16'hAE06, 1'b0, lat, nw, ni);
    check_eq("cmp66_lat", lat, 4);
    check_eq("cmp66_nowrite", nw, 0);
    check_eq("cmp66_c", {16'h0, C}, 32'd0);
    check_eq("cmp66_stat", {29'h0, stat}, 32'b001);

    // MVN R6,R1
    start(16'hB8C1);
    step("mvn_decode", o_zero);
    step("mvn_getb", o_getb);
    step("mvn_alu", eo(0, 3'b000, 0, 0, 0, 0, 1, 0, 2'b11, 1, 1, 0));
    step("mvn_wreg", o_wreg);
    check_eq("mvn_wait", {17'h0, outs}, {17'h0, o_wait});
    check_eq("mvn_r6", {16'h0, R[6]}, 32'hFFFA);
    check_eq("mvn_stat", {29'h0, stat}, 32'b100);

    // MOV R5,R5,LSR with R5=1
    run("movi_r5", 16'hD501, 1'b0, lat, nw, ni);
    start(16'hC0B5);
    step("movr_decode", o_zero);
    step("movr_getb", o_getb);
    step("movr_alu", eo(0, 3'b000, 0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0));
    step("movr_wreg", o_wreg);
    check_eq("movr_wait", {17'h0, outs}, {17'h0, o_wait});
    check_eq("movr_r5", {16'h0, R[5]}, 32'd0);
    check_eq("movr_stat", {29'h0, stat}, 32'b001);

    // ADD R7,R1,R2 with opcode inputs changed to 111 mid-instruction
    run("add_corrupt", 16'hA1E2, 1'b1, lat, nw, ni);
    check_eq("addc_lat", lat, 5);
    check_eq("addc_nwrite", nw, 1);
    check_eq("addc_noill", ni, 0);
    check_eq("addc_r7", {16'h0, R[7]}, 32'd8);

    // Illegal opcodes
    start(16'h0000);
    step("ill_decode", o_ill);
    check_eq("ill_wait", {17'h0, outs}, {17'h0, o_wait});
    run("ill_c8", 16'hC800, 1'b0, lat, nw, ni);
    check_eq("ill_c8_lat", lat, 1);
    check_eq("ill_c8_pulse", ni, 1);
    check_eq("ill_c8_nowrite", nw, 0);

    // Reset during GET_B of ADD R0,R1,R2 abandons the instruction
    run("movi_r0", 16'hD055, 1'b0, lat, nw, ni);
    start(16'hA102);
    step("rmid_decode", o_zero);
    step("rmid_geta", o_geta);
    check_eq("rmid_getb", {17'h0, outs}, {17'h0, o_getb});
    reset = 1'b0;
    #1;
    check_eq("rmid_async", {17'h0, outs}, {17'h0, o_wait});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rmid_idle", {17'h0, outs}, {17'h0, o_wait});
    check_eq("rmid_r0", {16'h0, R[0]}, 32'h55);

    // Back-to-back MOV imm with s held high
    ir = 16'hD402; s = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!w && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check_eq("b2b_lat1", lat, 3);
    check_eq("b2b_w", {31'h0, w}, 32'h1);
    ir = 16'hD307;
    @(negedge clk);
    check_eq("b2b_relaunch", {17'h0, outs}, {17'h0, o_zero});
    s = 1'b0;
    lat = 0;
    while (!w && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check_eq("b2b_lat2", lat, 3);
    check_eq("b2b_r4", {16'h0, R[4]}, 32'd2);
    check_eq("b2b_r3", {16'h0, R[3]}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
